// File: rtl/ew_event_logger.sv
// ew_event_logger: timestamps threat-FSM transitions and system_fault rising
// edges into a first-word-fall-through FIFO that the host drains over a
// valid/ready port. Records arriving while the FIFO is full are dropped and
// counted (saturating at 255).
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   fsm_state    in   threat FSM state (3 bits)
//   comm_channel in   active channel (2 bits)
//   system_fault in   fault flag
//   clear        in   synchronous flush of FIFO and drop counter
//   evt_ready    in   consumer accepts head record
//   evt_valid    out  head record valid (decoded from registered count)
//   evt_data     out  head record {ts, prev_state, new_state, channel, fault}
//   evt_count    out  records stored
//   log_full     out  evt_count == DEPTH (decoded from registered count)
//   drop_cnt     out  dropped records, saturating
module ew_event_logger #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TS_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [2:0]               fsm_state,
    input  logic [1:0]               comm_channel,
    input  logic                     system_fault,
    input  logic                     clear,
    input  logic                     evt_ready,
    output logic                     evt_valid,
    output logic [TS_W+8:0]          evt_data,
    output logic [$clog2(DEPTH):0]   evt_count,
    output logic                     log_full,
    output logic [7:0]               drop_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned REC_W = TS_W + 9;

    logic [TS_W-1:0]  ts_q, ts_d;
    logic [2:0]       last_state_q, last_state_d;
    logic             last_fault_q, last_fault_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       drop_q, drop_d;
    logic [REC_W-1:0] mem_q [DEPTH];

    logic             evt_fire;
    logic             pop;
    logic             push;
    logic             wr_en;
    logic [REC_W-1:0] rec;

    // Status decoded from the registered count only; no input-to-output path.
    assign evt_valid = (count_q != '0);
    assign log_full  = (count_q == CNT_W'(DEPTH));
    assign evt_count = count_q;
    assign drop_cnt  = drop_q;
    assign evt_data  = mem_q[rd_ptr_q];

    // Event detection, FIFO bookkeeping and drop accounting.
    always_comb begin
        ts_d         = ts_q + TS_W'(1);
        last_state_d = fsm_state;
        last_fault_d = system_fault;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        drop_d       = drop_q;
        wr_en        = 1'b0;

        // A state change and a fault edge in the same cycle share one record.
        evt_fire = (fsm_state != last_state_q) || (system_fault && !last_fault_q);
        pop      = evt_valid && evt_ready;
        // A full FIFO still accepts a push when the head leaves this cycle.
        push     = evt_fire && (!log_full || pop);
        rec      = {ts_q, last_state_q, fsm_state, comm_channel, system_fault};

        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            drop_d   = '0;
        end else begin
            if (push) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            if (evt_fire && !push && (drop_q != 8'hFF)) begin
                drop_d = drop_q + 8'd1;
            end
        end
    end

    // Control and tracking state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_q         <= '0;
            last_state_q <= '0;
            last_fault_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            drop_q       <= '0;
        end else begin
            ts_q         <= ts_d;
            last_state_q <= last_state_d;
            last_fault_q <= last_fault_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            drop_q       <= drop_d;
        end
    end

    // Record storage; contents are meaningless until counted, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= rec;
        end
    end

endmodule

// File: tb/tb_ew_event_logger.sv
module tb_ew_event_logger;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned TS_W  = 12;
    localparam int unsigned REC_W = TS_W + 9;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef logic [REC_W-1:0] rec_t;

    typedef struct {
        logic [2:0] fsm;
        logic [1:0] ch;
        logic       flt;
        logic       rdy;
        logic       exp_v;
        int         exp_cnt;
        rec_t       exp_data;
    } vec_t;

    logic             clk;
    logic             reset;
    logic [2:0]       fsm_state;
    logic [1:0]       comm_channel;
    logic             system_fault;
    logic             clear;
    logic             evt_ready;
    logic             evt_valid;
    logic [REC_W-1:0] evt_data;
    logic [CNT_W-1:0] evt_count;
    logic             log_full;
    logic [7:0]       drop_cnt;

    int n_cmp;
    int n_bad;

    // Reference model state
    rec_t            mq[$];
    int              m_drop;
    logic [TS_W-1:0] m_ts;
    logic [2:0]      m_last;
    logic            m_lastf;

    vec_t tbl[15];

    ew_event_logger #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .fsm_state    (fsm_state),
        .comm_channel (comm_channel),
        .system_fault (system_fault),
        .clear        (clear),
        .evt_ready    (evt_ready),
        .evt_valid    (evt_valid),
        .evt_data     (evt_data),
        .evt_count    (evt_count),
        .log_full     (log_full),
        .drop_cnt     (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic rec_t mk(input logic [TS_W-1:0] ts, input logic [2:0] p,
                                input logic [2:0] n, input logic [1:0] c, input logic f);
        return {ts, p, n, c, f};
    endfunction

    function automatic vec_t v(input logic [2:0] fsm, input logic [1:0] ch, input logic flt,
                               input logic rdy, input logic ev, input int cnt, input rec_t d);
        vec_t r;
        r.fsm = fsm; r.ch = ch; r.flt = flt; r.rdy = rdy;
        r.exp_v = ev; r.exp_cnt = cnt; r.exp_data = d;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        mq.delete();
        m_drop  = 0;
        m_ts    = '0;
        m_last  = '0;
        m_lastf = 1'b0;
    endtask

    task automatic check_model();
        check("mdl_valid", 64'(evt_valid), 64'(mq.size() != 0));
        check("mdl_count", 64'(evt_count), 64'(mq.size()));
        check("mdl_full",  64'(log_full),  64'(mq.size() == DEPTH));
        check("mdl_drop",  64'(drop_cnt),  64'(m_drop));
        if (mq.size() != 0) check("mdl_data", 64'(evt_data), 64'(mq[0]));
    endtask

    // Advance the model across one edge using the currently driven inputs,
    // then let the DUT take the same edge and compare.
    task automatic step();
        bit fire;
        if (clear) begin
            mq.delete();
            m_drop = 0;
        end else begin
            fire = (fsm_state != m_last) || (system_fault && !m_lastf);
            if (mq.size() != 0 && evt_ready) void'(mq.pop_front());
            if (fire) begin
                if (mq.size() < DEPTH) mq.push_back(mk(m_ts, m_last, fsm_state, comm_channel, system_fault));
                else if (m_drop < 255) m_drop++;
            end
        end
        m_ts    = m_ts + TS_W'(1);
        m_last  = fsm_state;
        m_lastf = system_fault;
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 64'(evt_valid), 64'(0));
        check({tag, "_count"}, 64'(evt_count), 64'(0));
        check({tag, "_full"},  64'(log_full),  64'(0));
        check({tag, "_drop"},  64'(drop_cnt),  64'(0));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        m_reset();
        #1;
        check_reset_outputs("rst");
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        logic [TS_W-1:0] t0;
        int guard;
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        fsm_state = '0; comm_channel = '0; system_fault = 1'b0;
        clear = 1'b0; evt_ready = 1'b0;
        m_reset();

        // Reset and idle for 20 cycles
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step();
            check("idle_valid", 64'(evt_valid), 64'(0));
            check("idle_count", 64'(evt_count), 64'(0));
            check("idle_drop",  64'(drop_cnt),  64'(0));
        end

        // Table: row index == edge index after reset release
        do_reset();
        tbl[0]  = v(3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 0, '0);
        tbl[1]  = v(3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 0, '0);
        tbl[2]  = v(3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 0, '0);
        tbl[3]  = v(3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 0, '0);
        tbl[4]  = v(3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 0, '0);
        tbl[5]  = v(3'd1, 2'd2, 1'b0, 1'b0, 1'b1, 1, mk(12'd5, 3'd0, 3'd1, 2'd2, 1'b0));
        tbl[6]  = v(3'd1, 2'd2, 1'b0, 1'b0, 1'b1, 1, mk(12'd5, 3'd0, 3'd1, 2'd2, 1'b0));
        tbl[7]  = v(3'd1, 2'd2, 1'b0, 1'b1, 1'b0, 0, '0);
        tbl[8]  = v(3'd1, 2'd2, 1'b1, 1'b0, 1'b1, 1, mk(12'd8, 3'd1, 3'd1, 2'd2, 1'b1));
        tbl[9]  = v(3'd1, 2'd2, 1'b1, 1'b0, 1'b1, 1, mk(12'd8, 3'd1, 3'd1, 2'd2, 1'b1));
        tbl[10] = v(3'd1, 2'd2, 1'b0, 1'b0, 1'b1, 1, mk(12'd8, 3'd1, 3'd1, 2'd2, 1'b1));
        tbl[11] = v(3'd3, 2'd1, 1'b1, 1'b0, 1'b1, 2, mk(12'd8, 3'd1, 3'd1, 2'd2, 1'b1));
        tbl[12] = v(3'd3, 2'd1, 1'b1, 1'b1, 1'b1, 1, mk(12'd11, 3'd1, 3'd3, 2'd1, 1'b1));
        tbl[13] = v(3'd3, 2'd1, 1'b1, 1'b1, 1'b0, 0, '0);
        tbl[14] = v(3'd3, 2'd1, 1'b1, 1'b0, 1'b0, 0, '0);
        for (int i = 0; i < 15; i++) begin
            fsm_state = tbl[i].fsm; comm_channel = tbl[i].ch;
            system_fault = tbl[i].flt; evt_ready = tbl[i].rdy; clear = 1'b0;
            step();
            check($sformatf("tbl%0d_valid", i), 64'(evt_valid), 64'(tbl[i].exp_v));
            check($sformatf("tbl%0d_count", i), 64'(evt_count), 64'(tbl[i].exp_cnt));
            check($sformatf("tbl%0d_drop", i),  64'(drop_cnt),  64'(0));
            if (tbl[i].exp_v) check($sformatf("tbl%0d_data", i), 64'(evt_data), 64'(tbl[i].exp_data));
        end

        // Overflow: 12 toggles into an 8-deep FIFO
        system_fault = 1'b0; evt_ready = 1'b0;
        t0 = m_ts;
        for (int k = 0; k < 12; k++) begin
            fsm_state = (k % 2 == 0) ? 3'd1 : 3'd2;
            step();
        end
        check("ovf_full",  64'(log_full),  64'(1));
        check("ovf_count", 64'(evt_count), 64'(8));
        check("ovf_drop",  64'(drop_cnt),  64'(4));
        check("ovf_head_ts", 64'(evt_data[REC_W-1 -: TS_W]), 64'(t0));

        // Full with simultaneous push and pop
        fsm_state = 3'd1; evt_ready = 1'b1;
        step();
        check("fpp_count", 64'(evt_count), 64'(8));
        check("fpp_drop",  64'(drop_cnt),  64'(4));
        check("fpp_head_ts", 64'(evt_data[REC_W-1 -: TS_W]), 64'(t0 + TS_W'(1)));
        for (int k = 2; k <= 4; k++) begin
            step();
            check($sformatf("drain_ts%0d", k), 64'(evt_data[REC_W-1 -: TS_W]), 64'(t0 + TS_W'(k)));
        end
        check("pre_clr_count", 64'(evt_count), 64'(5));

        // Clear with an event pending in the same cycle
        evt_ready = 1'b0; clear = 1'b1; fsm_state = 3'd2;
        step();
        clear = 1'b0;
        check("clr_count", 64'(evt_count), 64'(0));
        check("clr_drop",  64'(drop_cnt),  64'(0));
        check("clr_valid", 64'(evt_valid), 64'(0));
        step();

        // Randomized traffic with varying consumer rate
        for (int seg = 0; seg < 4; seg++) begin
            for (int i = 0; i < 150; i++) begin
                if ($urandom_range(0, 3) == 0) fsm_state = 3'($urandom_range(0, 6));
                if ($urandom_range(0, 4) == 0) system_fault = ~system_fault;
                comm_channel = 2'($urandom_range(0, 3));
                evt_ready = ($urandom_range(0, 3) < seg);
                clear = ($urandom_range(0, 99) == 0);
                step();
            end
        end
        clear = 1'b0; evt_ready = 1'b0; system_fault = 1'b0;

        // Timestamp wrap: log an event exactly where ts_cnt rolls to 0
        clear = 1'b1;
        step();
        clear = 1'b0;
        guard = 0;
        while (m_ts != '0 && guard < 5000) begin
            step();
            guard++;
        end
        check("wrap_reached", 64'(guard < 5000), 64'(1));
        fsm_state = fsm_state + 3'd1;
        if (fsm_state == 3'd7) fsm_state = 3'd0;
        step();
        check("wrap_valid", 64'(evt_valid), 64'(1));
        check("wrap_ts",    64'(evt_data[REC_W-1 -: TS_W]), 64'(0));

        // Reset asserted mid-drain, checked before any clock edge
        evt_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            fsm_state = (k % 2 == 0) ? 3'd4 : 3'd5;
            step();
        end
        evt_ready = 1'b1;
        step();
        step();
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("midrst");
        m_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        evt_ready = 1'b0; fsm_state = 3'd0; system_fault = 1'b0;
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
